mmul_parallel_tcdm_slice: RTL and testbench



---
 rtl/mmul_parallel_tcdm_slice.sv | 145 ++++++++++++++
 tb/tb_mmul_parallel_tcdm_slice.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mmul_parallel_tcdm_slice.sv
// Per-port TCDM request slice: 2-entry request skid buffer, outstanding-read limiter, in-order response path.
// Optional response register stage enabled by defining MMUL_PARALLEL_TCDM_SLICE_RESP_REG_EN.
module mmul_parallel_tcdm_slice #(
    parameter int MP      = 3,
    parameter int MAX_OUT = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [MP-1:0]        in_req,
    output logic [MP-1:0]        in_gnt,
    input  logic [MP-1:0][31:0]  in_add,
    input  logic [MP-1:0]        in_wen,
    input  logic [MP-1:0][3:0]   in_be,
    input  logic [MP-1:0][31:0]  in_data,
    output logic [MP-1:0][31:0]  in_r_data,
    output logic [MP-1:0]        in_r_valid,
    output logic [MP-1:0]        out_req,
    input  logic [MP-1:0]        out_gnt,
    output logic [MP-1:0][31:0]  out_add,
    output logic [MP-1:0]        out_wen,
    output logic [MP-1:0][3:0]   out_be,
    output logic [MP-1:0][31:0]  out_data,
    input  logic [MP-1:0][31:0]  out_r_data,
    input  logic [MP-1:0]        out_r_valid
);

    localparam int              CW      = $clog2(MAX_OUT + 1);
    localparam logic [CW-1:0]   CNT_MAX = CW'(MAX_OUT);
    localparam logic [CW-1:0]   CNT_ONE = CW'(1);
    localparam logic [CW-1:0]   CNT_ZERO = CW'(0);

    typedef struct packed {
        logic [31:0] add;
        logic        wen;
        logic [3:0]  be;
        logic [31:0] data;
    } entry_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    for (genvar ii = 0; ii < MP; ii++) begin : g_lane
        state_t        state_r, state_s;
        entry_t        head_r, tail_r, in_entry_s;
        logic [CW-1:0] cnt_r;
        logic          gnt_s, req_s, push_s, pop_s, read_pop_s;

        assign in_entry_s = {in_add[ii], in_wen[ii], in_be[ii], in_data[ii]};
        // Grant depends only on registered occupancy, never on out_gnt.
        assign gnt_s      = (state_r != FULL) & ~rst_i;
        assign req_s      = (state_r != EMPTY) & ~(head_r.wen & (cnt_r == CNT_MAX));
        assign push_s     = in_req[ii] & gnt_s;
        assign pop_s      = req_s & out_gnt[ii];
        assign read_pop_s = pop_s & head_r.wen;

        assign in_gnt[ii]   = gnt_s;
        assign out_req[ii]  = req_s;
        assign out_add[ii]  = head_r.add;
        assign out_wen[ii]  = head_r.wen;
        assign out_be[ii]   = head_r.be;
        assign out_data[ii] = head_r.data;

        // Buffer occupancy next-state logic
        always_comb begin
            state_s = state_r;
            case (state_r)
                EMPTY: begin
                    if (push_s) state_s = ONE;
                    else        state_s = EMPTY;
                end
                ONE: begin
                    if (push_s && !pop_s)      state_s = FULL;
                    else if (!push_s && pop_s) state_s = EMPTY;
                    else                       state_s = ONE;
                end
                FULL: begin
                    if (pop_s) state_s = ONE;
                    else       state_s = FULL;
                end
                default: state_s = EMPTY;
            endcase
        end

        // Buffer occupancy state register
        always_ff @(posedge clk_i) begin
            if (rst_i) state_r <= EMPTY;
            else       state_r <= state_s;
        end

        // Entry storage: head feeds the interconnect, tail shifts into head on pop
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                head_r <= '0;
                tail_r <= '0;
            end else begin
                case (state_r)
                    EMPTY: if (push_s) head_r <= in_entry_s;
                    ONE: begin
                        if (push_s && pop_s) head_r <= in_entry_s;
                        else if (push_s)     tail_r <= in_entry_s;
                    end
                    FULL:    if (pop_s) head_r <= tail_r;
                    default: head_r <= head_r;
                endcase
            end
        end

        // Outstanding-read counter; a stray response at zero leaves it at zero
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                cnt_r <= CNT_ZERO;
            end else if (read_pop_s && !out_r_valid[ii]) begin
                cnt_r <= cnt_r + CNT_ONE;
            end else if (!read_pop_s && out_r_valid[ii] && (cnt_r != CNT_ZERO)) begin
                cnt_r <= cnt_r - CNT_ONE;
            end
        end

`ifdef MMUL_PARALLEL_TCDM_SLICE_RESP_REG_EN
        logic [31:0] r_data_r;
        logic        r_valid_r;

        // One-cycle response register stage
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                r_data_r  <= 32'd0;
                r_valid_r <= 1'b0;
            end else begin
                r_data_r  <= out_r_data[ii];
                r_valid_r <= out_r_valid[ii];
            end
        end

        assign in_r_data[ii]  = r_data_r;
        assign in_r_valid[ii] = r_valid_r & ~rst_i;
`else
        assign in_r_data[ii]  = out_r_data[ii];
        assign in_r_valid[ii] = out_r_valid[ii] & ~rst_i;
`endif
    end

endmodule

// File: tb/tb_mmul_parallel_tcdm_slice.sv
// Directed self-checking bench for mmul_parallel_tcdm_slice (lane 0 exercised, lanes 1/2 for independence).
module tb_mmul_parallel_tcdm_slice;
    localparam int MP = 3;

    logic                clk_i = 1'b0;
    logic                rst_i;
    logic [MP-1:0]       in_req, in_gnt, in_wen, in_r_valid;
    logic [MP-1:0][31:0] in_add, in_data, in_r_data;
    logic [MP-1:0][3:0]  in_be, out_be;
    logic [MP-1:0]       out_req, out_gnt, out_wen, out_r_valid;
    logic [MP-1:0][31:0] out_add, out_data, out_r_data;

    int tests_run    = 0;
    int tests_failed = 0;
    int base;
    logic [31:0] pop_q[$];

    mmul_parallel_tcdm_slice #(.MP(MP), .MAX_OUT(4)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .in_req(in_req), .in_gnt(in_gnt), .in_add(in_add), .in_wen(in_wen),
        .in_be(in_be), .in_data(in_data), .in_r_data(in_r_data), .in_r_valid(in_r_valid),
        .out_req(out_req), .out_gnt(out_gnt), .out_add(out_add), .out_wen(out_wen),
        .out_be(out_be), .out_data(out_data), .out_r_data(out_r_data), .out_r_valid(out_r_valid)
    );

    always #5 clk_i = ~clk_i;

    // Record every request handed to the interconnect on lane 0
    always @(negedge clk_i) begin
        if (out_req[0] && out_gnt[0]) pop_q.push_back(out_add[0]);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic send(input int p, input logic [31:0] a, input logic w);
        int n;
        n = 0;
        in_req[p]  = 1'b1;
        in_add[p]  = a;
        in_wen[p]  = w;
        in_be[p]   = 4'hF;
        in_data[p] = a ^ 32'h5A5A_0000;
        @(negedge clk_i);
        while (!in_gnt[p] && n < 20) begin
            tick();
            n++;
            @(negedge clk_i);
        end
        if (n >= 20) check_eq("send_timeout", 32'd0, 32'd1);
        tick();
        in_req[p] = 1'b0;
    endtask

    initial begin
        rst_i = 1'b1; in_req = '0; in_add = '0; in_wen = '0; in_be = '0; in_data = '0;
        out_gnt = '0; out_r_data = '0; out_r_valid = '0;

        // Reset state
        tick();
        @(negedge clk_i);
        check_eq("rst_gnt", 32'(in_gnt), 32'd0);
        check_eq("rst_req", 32'(out_req), 32'd0);
        check_eq("rst_add", out_add[0], 32'd0);
        check_eq("rst_wen", 32'(out_wen), 32'd0);
        tick();
        rst_i = 1'b0;
        @(negedge clk_i);
        check_eq("post_rst_gnt", 32'(in_gnt), 32'd7);
        tick();

        // Test 1: stream 8 writes with out_gnt held high
        out_gnt = 3'b001;
        base = pop_q.size();
        for (int i = 0; i <= 8; i++) begin
            if (i < 8) begin
                in_req[0] = 1'b1; in_add[0] = 32'h100 + 32'(4 * i); in_wen[0] = 1'b0;
                in_be[0] = 4'hF; in_data[0] = 32'(i);
            end else begin
                in_req[0] = 1'b0;
            end
            @(negedge clk_i);
            if (i < 8) check_eq("t1_gnt", 32'(in_gnt[0]), 32'd1);
            if (i > 0) begin
                check_eq("t1_req", 32'(out_req[0]), 32'd1);
                check_eq("t1_add", out_add[0], 32'h100 + 32'(4 * (i - 1)));
            end
            tick();
        end
        @(negedge clk_i);
        check_eq("t1_idle", 32'(out_req[0]), 32'd0);
        check_eq("t1_pops", 32'(pop_q.size() - base), 32'd8);
        tick();

        // Test 2: backpressure fills the slice, release drains in order
        out_gnt = 3'b000;
        in_req[0] = 1'b1; in_wen[0] = 1'b0; in_add[0] = 32'h400;
        @(negedge clk_i); check_eq("t2_gnt_a", 32'(in_gnt[0]), 32'd1); tick();
        in_add[0] = 32'h404;
        @(negedge clk_i); check_eq("t2_gnt_b", 32'(in_gnt[0]), 32'd1); tick();
        in_add[0] = 32'h408;
        @(negedge clk_i);
        check_eq("t2_full_gnt", 32'(in_gnt[0]), 32'd0);
        check_eq("t2_req", 32'(out_req[0]), 32'd1);
        check_eq("t2_head_a", out_add[0], 32'h400);
        tick();
        out_gnt[0] = 1'b1;
        @(negedge clk_i);
        check_eq("t2_full_gnt2", 32'(in_gnt[0]), 32'd0);
        check_eq("t2_pop_a", out_add[0], 32'h400);
        tick();
        @(negedge clk_i);
        check_eq("t2_gnt_c", 32'(in_gnt[0]), 32'd1);
        check_eq("t2_pop_b", out_add[0], 32'h404);
        tick();
        in_req[0] = 1'b0;
        @(negedge clk_i);
        check_eq("t2_req_c", 32'(out_req[0]), 32'd1);
        check_eq("t2_pop_c", out_add[0], 32'h408);
        tick();
        @(negedge clk_i); check_eq("t2_idle", 32'(out_req[0]), 32'd0); tick();

        // Test 3: six reads, limiter stops after four
        base = pop_q.size();
        for (int i = 0; i < 6; i++) send(0, 32'h200 + 32'(4 * i), 1'b1);
        tick(); tick();
        @(negedge clk_i);
        check_eq("t3_blocked", 32'(out_req[0]), 32'd0);
        check_eq("t3_pops", 32'(pop_q.size() - base), 32'd4);
        for (int k = 0; k < 4; k++) check_eq("t3_order", pop_q[base + k], 32'h200 + 32'(4 * k));
        tick();
        out_r_valid[0] = 1'b1; out_r_data[0] = 32'h1111_0000;
        @(negedge clk_i);
        check_eq("t3_still_blocked", 32'(out_req[0]), 32'd0);
`ifndef MMUL_PARALLEL_TCDM_SLICE_RESP_REG_EN
        check_eq("t3_rvalid", 32'(in_r_valid[0]), 32'd1);
        check_eq("t3_rdata", in_r_data[0], 32'h1111_0000);
`endif
        tick();
        out_r_valid[0] = 1'b0;
        @(negedge clk_i);
        check_eq("t3_one_more", 32'(out_req[0]), 32'd1);
        check_eq("t3_one_more_add", out_add[0], 32'h210);
`ifdef MMUL_PARALLEL_TCDM_SLICE_RESP_REG_EN
        check_eq("t3_rvalid_reg", 32'(in_r_valid[0]), 32'd1);
        check_eq("t3_rdata_reg", in_r_data[0], 32'h1111_0000);
`endif
        tick();
        @(negedge clk_i);
        check_eq("t3_reblocked", 32'(out_req[0]), 32'd0);
        check_eq("t3_pops5", 32'(pop_q.size() - base), 32'd5);
        tick();

        // Test 4: write held behind blocked read; pop and response together keep the count
        send(0, 32'h300, 1'b0);
        @(negedge clk_i);
        check_eq("t4_write_held", 32'(out_req[0]), 32'd0);
        check_eq("t4_head", out_add[0], 32'h214);
        tick();
        out_r_valid[0] = 1'b1;
        @(negedge clk_i); check_eq("t4_blocked", 32'(out_req[0]), 32'd0); tick();
        @(negedge clk_i);
        check_eq("t4_read_pop", 32'(out_req[0]), 32'd1);
        check_eq("t4_read_add", out_add[0], 32'h214);
        tick();
        out_r_valid[0] = 1'b0;
        @(negedge clk_i);
        check_eq("t4_write_req", 32'(out_req[0]), 32'd1);
        check_eq("t4_write_add", out_add[0], 32'h300);
        check_eq("t4_write_wen", 32'(out_wen[0]), 32'd0);
        tick();
        @(negedge clk_i); check_eq("t4_idle", 32'(out_req[0]), 32'd0); tick();
        base = pop_q.size();
        send(0, 32'h310, 1'b1);
        send(0, 32'h314, 1'b1);
        tick(); tick();
        @(negedge clk_i);
        check_eq("t4_cnt3_pops", 32'(pop_q.size() - base), 32'd1);
        check_eq("t4_cnt_full", 32'(out_req[0]), 32'd0);
        tick();

        // Test 5: reset with two buffered requests and two reads outstanding
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        out_gnt[0] = 1'b1;
        send(0, 32'h500, 1'b1);
        send(0, 32'h504, 1'b1);
        tick();
        out_gnt[0] = 1'b0;
        send(0, 32'h510, 1'b0);
        send(0, 32'h514, 1'b0);
        rst_i = 1'b1; out_gnt[0] = 1'b1; out_r_valid[0] = 1'b1; out_r_data[0] = 32'h0000_BEEF;
        @(negedge clk_i);
        check_eq("t5_rst_gnt", 32'(in_gnt[0]), 32'd0);
        check_eq("t5_rst_rvalid", 32'(in_r_valid[0]), 32'd0);
        tick();
        rst_i = 1'b0;
        @(negedge clk_i);
        check_eq("t5_req_cleared", 32'(out_req[0]), 32'd0);
        check_eq("t5_add_cleared", out_add[0], 32'd0);
        check_eq("t5_gnt_back", 32'(in_gnt[0]), 32'd1);
`ifndef MMUL_PARALLEL_TCDM_SLICE_RESP_REG_EN
        check_eq("t5_stray_fwd", 32'(in_r_valid[0]), 32'd1);
`endif
        tick();
        out_r_valid[0] = 1'b0;
        base = pop_q.size();
        for (int i = 0; i < 6; i++) send(0, 32'h600 + 32'(4 * i), 1'b1);
        tick(); tick();
        @(negedge clk_i);
        check_eq("t5_cnt_zero_pops", 32'(pop_q.size() - base), 32'd4);
        check_eq("t5_blocked", 32'(out_req[0]), 32'd0);
        tick();

        // Test 6: response latency on lane 2
        out_r_valid[2] = 1'b1; out_r_data[2] = 32'hDEAD_BEEF;
        @(negedge clk_i);
`ifdef MMUL_PARALLEL_TCDM_SLICE_RESP_REG_EN
        check_eq("t6_rvalid_t", 32'(in_r_valid[2]), 32'd0);
        tick();
        out_r_valid[2] = 1'b0; out_r_data[2] = 32'd0;
        @(negedge clk_i);
        check_eq("t6_rvalid_t1", 32'(in_r_valid[2]), 32'd1);
        check_eq("t6_rdata_t1", in_r_data[2], 32'hDEAD_BEEF);
`else
        check_eq("t6_rvalid_t", 32'(in_r_valid[2]), 32'd1);
        check_eq("t6_rdata_t", in_r_data[2], 32'hDEAD_BEEF);
        tick();
        out_r_valid[2] = 1'b0; out_r_data[2] = 32'd0;
        @(negedge clk_i);
        check_eq("t6_rvalid_t1", 32'(in_r_valid[2]), 32'd0);
`endif
        check_eq("lanes_idle", 32'(out_req[2:1]), 32'd0);
        check_eq("lanes_gnt", 32'(in_gnt[2:1]), 32'd3);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
